// File: rtl/fetch_pkg.sv
// Shared types and constants for the WISC instruction-fetch stage.
package fetch_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_HOLD   = 2'd1,
    ST_DROP   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  localparam word_t      NOP_INSTR   = 16'h0800;
  localparam logic [4:0] HALT_OPCODE = 5'b00000;

  typedef struct packed {
    word_t instr;
    word_t pc_plus2;
    logic  valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc_plus2: 16'h0000, valid: 1'b0};

  function automatic logic is_halt(input word_t w);
    return w[15:11] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats load, otherwise holds; zero-latency write on the edge.
// No backpressure of its own; the fetch stage decides load/hold/bubble each cycle.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_load,
  input  logic  i_bubble,
  input  ifid_t i_dat,
  output ifid_t o_dat
);

  ifid_t r_dat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dat <= IFID_BUBBLE;
    end else if (i_bubble) begin
      r_dat <= IFID_BUBBLE;
    end else if (i_load) begin
      r_dat <= i_dat;
    end
  end

  assign o_dat = r_dat;

endmodule

// File: rtl/fetch_stage.sv
// WISC fetch stage + IF/ID: one outstanding imem read, response to instr_d in one edge, stall freezes PC/IF/ID.
// Optional FETCH_ALIGN_CHECK_EN: odd redirect targets raise sticky fetch_err and halt fetch.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter word_t RESET_PC = 16'h0000
)
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [15:0] o_imem_addr,
  input  logic        i_imem_valid,
  input  logic [15:0] i_imem_rdata,
  output logic [15:0] o_instr_d,
  output logic [15:0] o_pc_plus2_d,
  output logic        o_valid_d,
  output logic        o_fetch_err
);

  state_t r_state;
  word_t  r_pc;
  word_t  r_hold;
  logic   r_outstanding;

  logic   w_resp;
  logic   w_accept;
  logic   w_release;
  logic   w_req;
  logic   w_load;
  logic   w_bubble;
  logic   w_misalign;
  word_t  w_pc_plus2;
  word_t  w_target;
  word_t  w_load_word;
  ifid_t  w_ifid_in;
  ifid_t  w_ifid_q;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_fetch_err;

  assign w_target   = i_redirect_pc;
  assign w_misalign = i_redirect_pc[0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_err <= 1'b0;
    end else if (i_redirect && w_misalign) begin
      r_fetch_err <= 1'b1;
    end
  end

  assign o_fetch_err = r_fetch_err;
`else
  logic w_unused_pc0;

  assign w_target     = {i_redirect_pc[15:1], 1'b0};
  assign w_misalign   = 1'b0;
  assign w_unused_pc0 = i_redirect_pc[0];
  assign o_fetch_err  = 1'b0;
`endif

  // Responses arriving with nothing outstanding are stale (e.g. issued before reset).
  assign w_resp     = i_imem_valid & r_outstanding;
  assign w_pc_plus2 = r_pc + 16'd2;
  assign w_accept   = !i_redirect && (r_state == ST_FETCH) && w_resp && !i_stall;
  assign w_release  = !i_redirect && (r_state == ST_HOLD) && !i_stall;

  // r_pc is the address of the word in flight; on accept the next request already targets pc+2.
  assign w_req = !i_redirect && (r_state == ST_FETCH) &&
                 (!r_outstanding || (w_accept && !is_halt(i_imem_rdata)));

  assign o_imem_req  = w_req & i_rst_n;
  assign o_imem_addr = w_accept ? w_pc_plus2 : r_pc;

  assign w_load      = w_accept | w_release;
  assign w_bubble    = i_redirect | (!i_stall & !w_load);
  assign w_load_word = w_release ? r_hold : i_imem_rdata;
  assign w_ifid_in   = '{instr: w_load_word, pc_plus2: w_pc_plus2, valid: 1'b1};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_FETCH;
      r_pc          <= RESET_PC;
      r_hold        <= NOP_INSTR;
      r_outstanding <= 1'b0;
    end else begin
      r_outstanding <= w_req | (r_outstanding & !i_imem_valid);
      if (i_redirect) begin
        r_pc <= w_target;
        if (w_misalign) begin
          r_state <= ST_HALTED;
        end else if (r_outstanding && !i_imem_valid) begin
          r_state <= ST_DROP;
        end else begin
          r_state <= ST_FETCH;
        end
      end else begin
        case (r_state)
          ST_FETCH: begin
            if (w_resp && i_stall) begin
              r_hold  <= i_imem_rdata;
              r_state <= ST_HOLD;
            end else if (w_resp) begin
              r_pc <= w_pc_plus2;
              if (is_halt(i_imem_rdata)) begin
                r_state <= ST_HALTED;
              end
            end
          end
          ST_HOLD: begin
            if (!i_stall) begin
              r_pc    <= w_pc_plus2;
              r_state <= is_halt(r_hold) ? ST_HALTED : ST_FETCH;
            end
          end
          ST_DROP: begin
            if (w_resp) begin
              r_state <= ST_FETCH;
            end
          end
          default: ;
        endcase
      end
    end
  end

  if_id_reg u_if_id (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (w_load),
    .i_bubble (w_bubble),
    .i_dat    (w_ifid_in),
    .o_dat    (w_ifid_q)
  );

  assign o_instr_d    = w_ifid_q.instr;
  assign o_pc_plus2_d = w_ifid_q.pc_plus2;
  assign o_valid_d    = w_ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: variable-latency memory responder, program-order scoreboard, directed and random phases.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        imem_valid = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        o_imem_req;
  logic [15:0] o_imem_addr;
  logic [15:0] o_instr_d;
  logic [15:0] o_pc_plus2_d;
  logic        o_valid_d;
  logic        o_fetch_err;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int lat = 1;
  int inflight = 0;
  int n_consumed = 0;

  logic [15:0] mem [32768];
  logic [31:0] exp_q [$];

  typedef struct {
    int          due;
    logic [15:0] word;
  } resp_t;
  resp_t rsp_q [$];

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_stall       (stall),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_valid  (imem_valid),
    .i_imem_rdata  (imem_rdata),
    .o_instr_d     (o_instr_d),
    .o_pc_plus2_d  (o_pc_plus2_d),
    .o_valid_d     (o_valid_d),
    .o_fetch_err   (o_fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural fetch stream from a start address: sequential words up to and including a HALT.
  task automatic sb_restart(input logic [15:0] start);
    logic [15:0] p;
    logic [15:0] w;
    logic [15:0] np;
    exp_q.delete();
    p = start;
    for (int i = 0; i < 1024; i++) begin
      w  = mem[p[15:1]];
      np = p + 16'd2;
      exp_q.push_back({w, np});
      if (w[15:11] == 5'b00000) break;
      p = np;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at/after a negedge; scans the current cycle first.
  task automatic wait_req(input string name, output logic [15:0] addr);
    addr = 16'hxxxx;
    for (int i = 0; i < 40; i++) begin
      if (o_imem_req === 1'b1) begin
        addr = o_imem_addr;
        return;
      end
      @(negedge clk);
    end
    n_vec++;
    n_err++;
    $display("FAIL %s: got no imem_req within 40 cycles, expected one", name);
  endtask

  initial begin : responder
    int avail;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        inflight = 0;
      end else begin
        avail = inflight - (imem_valid ? 1 : 0);
        if (avail < 0) avail = 0;
        if (o_imem_req) begin
          check("one_outstanding", 32'(avail), 32'd0);
          rsp_q.push_back('{due: cyc + lat, word: mem[o_imem_addr[15:1]]});
        end
        inflight = avail + (o_imem_req ? 1 : 0);
      end
      @(posedge clk);
      cyc++;
      #1;
      imem_valid = 1'b0;
      imem_rdata = 16'($urandom);
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        imem_valid = 1'b1;
        imem_rdata = rsp_q[0].word;
        void'(rsp_q.pop_front());
      end
    end
  end

  // Decode consumes IF/ID on every unstalled, unflushed edge.
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && o_valid_d && !stall && !redirect) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_extra: got instr %h pc+2 %h, expected no instruction", o_instr_d, o_pc_plus2_d);
        end else begin
          e = exp_q.pop_front();
          check("sb_instr_pc2", {o_instr_d, o_pc_plus2_d}, e);
          n_consumed++;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [15:0] w;
    logic [15:0] a;
    logic [15:0] t;
    int          cnt;
    int          base;

    for (int i = 0; i < 32768; i++) begin
      w = 16'($urandom);
      if (w[15:11] == 5'b00000) w[11] = 1'b1;
      mem[i] = w;
    end
    for (int i = 0; i < 16; i++) mem[i] = 16'h4000 + 16'(i << 8);
    mem[16'h0206 >> 1] = 16'h0000;

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_imem_req", 32'(o_imem_req), 32'd0);
    check("rst_instr_d", 32'(o_instr_d), 32'h0800);
    check("rst_pc_plus2_d", 32'(o_pc_plus2_d), 32'd0);
    check("rst_valid_d", 32'(o_valid_d), 32'd0);
    check("rst_fetch_err", 32'(o_fetch_err), 32'd0);

    // sequential stream, 1-cycle memory
    tick();
    rst_n = 1'b1;
    sb_restart(16'h0000);
    @(negedge clk);
    check("first_req", 32'({o_imem_req, o_imem_addr}), 32'h1_0000);
    @(negedge clk);
    check("valid_after_edge1", 32'(o_valid_d), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("seq_instr_pc2", {o_instr_d, o_pc_plus2_d}, {16'h4000 + 16'((k - 1) << 8), 16'(2 * k)});
      check("seq_valid", 32'(o_valid_d), 32'd1);
    end

    // stall across a response: word parks in the hold buffer
    tick();
    stall = 1'b1;
    @(negedge clk);
    check("stall_no_req0", 32'(o_imem_req), 32'd0);
    tick();
    @(negedge clk);
    check("stall_no_req1", 32'(o_imem_req), 32'd0);
    tick();
    @(negedge clk);
    check("stall_no_req2", 32'(o_imem_req), 32'd0);
    tick();
    stall = 1'b0;
    @(negedge clk);
    check("release_no_req", 32'(o_imem_req), 32'd0);
    tick();
    @(negedge clk);
    check("req_after_release", 32'(o_imem_req), 32'd1);

    // redirect while a 3-cycle read is outstanding
    tick();
    lat = 3;
    @(negedge clk);
    wait_req("redir_out_setup", a);
    tick();
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    sb_restart(16'h0040);
    @(negedge clk);
    tick();
    redirect = 1'b0;
    lat = 1;
    @(negedge clk);
    check("redir_bubble", 32'(o_valid_d), 32'd0);
    check("redir_drop_no_req", 32'(o_imem_req), 32'd0);
    wait_req("redir_target_req", a);
    check("redir_target_addr", 32'(a), 32'h0040);

    // redirect and stall together
    repeat (4) tick();
    redirect = 1'b1;
    stall = 1'b1;
    redirect_pc = 16'h0100;
    sb_restart(16'h0100);
    tick();
    redirect = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    check("redir_stall_bubble", 32'(o_valid_d), 32'd0);
    wait_req("redir_stall_req", a);
    check("redir_stall_addr", 32'(a), 32'h0100);

    // HALT at 0x0206
    tick();
    redirect = 1'b1;
    redirect_pc = 16'h0200;
    sb_restart(16'h0200);
    tick();
    redirect = 1'b0;
    cnt = 0;
    while (cnt < 50 && !(o_valid_d && o_instr_d == 16'h0000)) begin
      @(negedge clk);
      cnt++;
    end
    check("halt_reached", 32'(o_valid_d && o_instr_d == 16'h0000), 32'd1);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      cnt += o_imem_req ? 1 : 0;
    end
    check("halt_no_req", 32'(cnt), 32'd0);
    check("halt_bubble", 32'(o_valid_d), 32'd0);
    check("halt_drained", 32'(exp_q.size()), 32'd0);
    tick();
    redirect = 1'b1;
    redirect_pc = 16'h0010;
    sb_restart(16'h0010);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    wait_req("halt_resume_req", a);
    check("halt_resume_addr", 32'(a), 32'h0010);

    // odd redirect target
    repeat (3) tick();
    redirect = 1'b1;
    redirect_pc = 16'h0011;
`ifdef FETCH_ALIGN_CHECK_EN
    exp_q.delete();
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check("align_err_set", 32'(o_fetch_err), 32'd1);
    check("align_bubble", 32'(o_valid_d), 32'd0);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      cnt += o_imem_req ? 1 : 0;
    end
    check("align_no_req", 32'(cnt), 32'd0);
    check("align_err_sticky", 32'(o_fetch_err), 32'd1);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("align_err_cleared", 32'(o_fetch_err), 32'd0);
    tick();
    rst_n = 1'b1;
    sb_restart(16'h0000);
`else
    sb_restart(16'h0010);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check("odd_target_no_err", 32'(o_fetch_err), 32'd0);
    wait_req("odd_target_req", a);
    check("odd_target_addr", 32'(a), 32'h0010);
`endif

    // random stall / latency / redirect traffic
    base = n_consumed;
    repeat (2500) begin
      tick();
      lat = $urandom_range(1, 3);
      stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) begin
        t = ($urandom_range(0, 9) == 0) ? 16'hFFF8 : 16'(2 * $urandom_range(16'h0800, 16'h1FFF));
        redirect = 1'b1;
        redirect_pc = t;
        sb_restart(t);
      end else begin
        redirect = 1'b0;
      end
    end
    tick();
    stall = 1'b0;
    redirect = 1'b1;
    redirect_pc = 16'h3000;
    sb_restart(16'h3000);
    tick();
    redirect = 1'b0;
    check("random_progress", 32'(n_consumed - base >= 400), 32'd1);

    // reset while a read is in flight; the late response must be ignored
    repeat (5) tick();
    lat = 2;
    @(negedge clk);
    wait_req("rst_mid_setup", a);
    tick();
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_req_low", 32'(o_imem_req), 32'd0);
    check("rst_mid_valid", 32'(o_valid_d), 32'd0);
    tick();
    rst_n = 1'b1;
    lat = 1;
    sb_restart(16'h0000);
    base = n_consumed;
    @(negedge clk);
    check("rst_mid_first_req", 32'({o_imem_req, o_imem_addr}), 32'h1_0000);
    repeat (20) tick();
    check("rst_mid_progress", 32'(n_consumed - base >= 10), 32'd1);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
